// File: rtl/uart_dbg_pkg.sv
// rtl/uart_dbg_pkg.sv - shared constants, state type and hex helper for the debug UART path
package uart_dbg_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam int         MSG_LEN     = 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // Uppercase hex: 'A' is 0x41, so letters are offset from 0x37.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or above the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [3:0]         ptr,
  output logic [3:0]         winner,
  output logic               any_req
);

  logic [15:0] req_pad;
  logic [4:0]  pos;

  assign req_pad = 16'(req);

  // Scan downward in offset so the smallest offset from ptr is assigned last and wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    pos     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + 5'(i);
      if (pos >= 5'(NUM_REQ)) pos = pos - 5'(NUM_REQ);
      if (req_pad[pos[3:0]]) begin
        winner  = pos[3:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx among debug requesters, "<id>:<HHHH>\r\n" per grant
module uart_tx_arbiter
  import uart_dbg_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_data_ready,
  output logic                  busy,
  output logic [3:0]            grant_id
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    ptr;
  logic [15:0]   word;
  logic [3:0]    winner;
  logic          any_req;
  logic [15:0]   words [16];

  for (genvar g = 0; g < 16; g++) begin : g_words
    if (g < NUM_REQ) begin : g_on
      assign words[g] = req_data[16*g +: 16];
    end else begin : g_off
      assign words[g] = '0;
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign idx_next = idx + 3'd1;

  function automatic logic [7:0] msg_byte(input logic [2:0] i, input logic [3:0] id,
                                          input logic [15:0] w);
    case (i)
      3'd0:    return hex_ascii(id);
      3'd1:    return ASCII_COLON;
      3'd2:    return hex_ascii(w[15:12]);
      3'd3:    return hex_ascii(w[11:8]);
      3'd4:    return hex_ascii(w[7:4]);
      3'd5:    return hex_ascii(w[3:0]);
      3'd6:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      req_ready     <= '0;
      busy          <= 1'b0;
      grant_id      <= '0;
      idx           <= '0;
      gap_cnt       <= '0;
      ptr           <= '0;
      word          <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            for (int i = 0; i < NUM_REQ; i++) req_ready[i] <= (winner == 4'(i));
            word          <= words[winner];
            grant_id      <= winner;
            ptr           <= (winner == 4'(NUM_REQ - 1)) ? 4'd0 : winner + 4'd1;
            tx_data       <= hex_ascii(winner);
            tx_data_valid <= 1'b1;
            idx           <= '0;
            busy          <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (tx_data_valid && tx_data_ready) begin
            if (idx == 3'(MSG_LEN - 1)) begin
              tx_data_valid <= 1'b0;
              idx           <= '0;
              if (GAP_CYCLES > 0) begin
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              idx     <= idx_next;
              tx_data <= msg_byte(idx_next, grant_id, word);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench for uart_tx_arbiter with GAP_CYCLES 0 and 5 instances
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    rv   [2];
  logic [16*N-1:0] rd   [2];
  logic            trdy [2];
  logic [N-1:0]    rq   [2];
  logic [7:0]      txd  [2];
  logic            txv  [2];
  logic            bsy  [2];
  logic [3:0]      gid  [2];

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rq[0]),
    .tx_data(txd[0]), .tx_data_valid(txv[0]), .tx_data_ready(trdy[0]), .busy(bsy[0]),
    .grant_id(gid[0])
  );

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rq[1]),
    .tx_data(txd[1]), .tx_data_valid(txv[1]), .tx_data_ready(trdy[1]), .busy(bsy[1]),
    .grant_id(gid[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: message-level view (bytes sent, gap cycles left, rr pointer) per instance.
  int         m_send [2];
  int         m_sent [2];
  int         m_gap  [2];
  int         m_ptr  [2];
  int         m_gid  [2];
  bit         m_fresh[2];
  logic [N-1:0] m_rr [2];
  logic [7:0] m_msg  [2][8];
  int         gapv   [2] = '{0, 5};
  string      hexs = "0123456789ABCDEF";

  logic            p_rst = 1'b0;
  logic [N-1:0]    p_rv  [2];
  logic [16*N-1:0] p_rd  [2];
  logic            p_rdy [2];

  int         glog[$];
  logic [7:0] blog[$];

  task automatic model_step(input int k);
    int w;
    int d;
    bit found;
    logic [15:0] wd;
    m_rr[k] = '0;
    if (!p_rst) begin
      m_send[k] = 0; m_sent[k] = 0; m_gap[k] = 0; m_ptr[k] = 0; m_gid[k] = 0; m_fresh[k] = 1'b1;
    end else if (m_send[k] != 0) begin
      if (p_rdy[k]) begin
        m_sent[k]++;
        if (m_sent[k] == 8) begin
          m_send[k] = 0;
          m_gap[k]  = gapv[k];
        end
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end else if (p_rv[k] != 0) begin
      found = 1'b0;
      w = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && p_rv[k][(m_ptr[k] + i) % N]) begin
          found = 1'b1;
          w = (m_ptr[k] + i) % N;
        end
      end
      m_ptr[k] = (w + 1) % N;
      m_gid[k] = w;
      m_rr[k]  = N'(1 << w);
      wd = p_rd[k][16*w +: 16];
      m_msg[k][0] = hexs[w];
      m_msg[k][1] = ":";
      for (int j = 0; j < 4; j++) begin
        d = int'((wd >> (12 - 4*j)) & 16'h000F);
        m_msg[k][2+j] = hexs[d];
      end
      m_msg[k][6] = 8'h0D;
      m_msg[k][7] = 8'h0A;
      m_send[k]  = 1;
      m_sent[k]  = 0;
      m_fresh[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      check($sformatf("req_ready%0d", k), 32'(rq[k]), 32'(m_rr[k]));
      check($sformatf("tx_valid%0d", k), 32'(txv[k]), 32'(m_send[k] != 0));
      check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(m_send[k] != 0 || m_gap[k] > 0));
      check($sformatf("grant_id%0d", k), 32'(gid[k]), 32'(m_gid[k]));
      if (m_send[k] != 0)
        check($sformatf("tx_data%0d", k), 32'(txd[k]), 32'(m_msg[k][m_sent[k]]));
      else if (m_fresh[k])
        check($sformatf("tx_data_rst%0d", k), 32'(txd[k]), 32'h0);
    end
    for (int i = 0; i < N; i++) if (rq[0][i]) glog.push_back(i);
    if (txv[0] && trdy[0]) blog.push_back(txd[0]);
    p_rst = rst_n;
    for (int k = 0; k < 2; k++) begin
      p_rv[k]  = rv[k];
      p_rd[k]  = rd[k];
      p_rdy[k] = trdy[k];
    end
  end

  // Requesters drop valid on their ready pulse; idle requesters keep scrambling their word.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        rv[k] = rv[k] & ~rq[k];
        for (int i = 0; i < N; i++)
          if (!rv[k][i]) rd[k][16*i +: 16] = 16'($urandom);
      end
    end
  endtask

  task automatic post(input logic [N-1:0] v);
    for (int k = 0; k < 2; k++) rv[k] = rv[k] | v;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    for (int k = 0; k < 2; k++) rd[k][16*i +: 16] = w;
  endtask

  task automatic check_bytes(input string tag, input string exp);
    check({tag, "_len"}, 32'(blog.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < blog.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(blog[i]), 32'(exp[i]));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rv[k] = '0; rd[k] = '0; trdy[k] = 1'b1;
    end
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // single request, ready tied high
    blog.delete();
    set_word(2, 16'hBEEF);
    post(4'b0100);
    tick(14);
    check_bytes("single", "2:BEEF\r\n");

    // round-robin from a fresh pointer
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    glog.delete();
    for (int i = 0; i < N; i++) set_word(i, 16'h1111 * 16'(i));
    post(4'b1111);
    tick(80);
    post(4'b1111);
    tick(80);
    post(4'b0001);
    tick(20);
    post(4'b1001);
    tick(50);
    check("rr_count", 32'(glog.size()), 32'd11);
    if (glog.size() == 11) begin
      for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(i % 4));
      check("rr_solo0", 32'(glog[8]), 32'd0);
      check("rr_3_before_0", 32'(glog[9]), 32'd3);
      check("rr_then0", 32'(glog[10]), 32'd0);
    end

    // backpressure 1,0,0 pattern
    post(4'b0010);
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < 2; k++) trdy[k] = (c % 3 == 0);
      tick(1);
    end
    for (int k = 0; k < 2; k++) trdy[k] = 1'b1;
    tick(30);

    // word captured at grant survives later requester changes
    blog.delete();
    set_word(1, 16'h1234);
    post(4'b0010);
    tick(2);
    set_word(1, 16'hFFFF);
    tick(12);
    check_bytes("hold", "1:1234\r\n");
    tick(20);

    // reset after byte 3 abandons the message and the pointer
    post(4'b0100);
    tick(5);
    rst_n = 1'b0;
    post(4'b0011);
    tick(1);
    check("rst_txv", 32'(txv[0]), 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_gid", 32'(gid[0]), 32'd0);
    rst_n = 1'b1;
    glog.delete();
    tick(40);
    check("rst_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("rst_first", 32'(glog[0]), 32'd0);
      check("rst_second", 32'(glog[1]), 32'd1);
    end

    // randomized traffic, backpressure and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        trdy[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) rv[k] = rv[k] | N'($urandom);
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
